tri_bbox_seq: RTL and testbench



---
 rtl/tri_bbox_seq_pkg.sv | 19 +
 rtl/tri_bbox_seq_min3_sel.sv | 58 +++++
 rtl/tri_bbox_seq.sv | 155 +++++++++++++++
 tb/tb_tri_bbox_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tri_bbox_seq_pkg.sv
// Shared definitions for the triangle bounding-box sequencer:
// datapath width, axis tags and the FSM state encoding.
package tri_bbox_seq_pkg;

    localparam int W = 32;

    localparam logic TAG_X = 1'b0;
    localparam logic TAG_Y = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SUB_X = 3'd1,
        ST_CMP_X = 3'd2,
        ST_SUB_Y = 3'd3,
        ST_CMP_Y = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/tri_bbox_seq_min3_sel.sv
// Combinational three-way min/max selector shared by the x and y passes.
// Ordering comes from the sign bit of the precomputed pairwise differences
// (a<b iff (a-b) is negative); the zero test on each difference makes tie
// handling deterministic. Offsets are taken from the selected minimum and
// carry the axis tag in the top bit.
module min3_sel
    import tri_bbox_seq_pkg::*;
(
    input  logic [W-1:0] p1,
    input  logic [W-1:0] p2,
    input  logic [W-1:0] p3,
    input  logic [W-1:0] d12,
    input  logic [W-1:0] d23,
    input  logic [W-1:0] d31,
    input  logic         tag,
    output logic [W-1:0] min,
    output logic [W-1:0] max,
    output logic [W-1:0] o1,
    output logic [W-1:0] o2,
    output logic [W-1:0] o3
);

    logic lt12, lt23, lt31;
    logic le12, le23, le31;
    logic [W-2:0] f1, f2, f3;

    // Pairwise order flags, then pick the extreme vertices and form offsets.
    always_comb begin
        lt12 = d12[W-1];
        lt23 = d23[W-1];
        lt31 = d31[W-1];
        le12 = lt12 | (d12 == '0);
        le23 = lt23 | (d23 == '0);
        le31 = lt31 | (d31 == '0);

        if (le12 && !lt31)
            min = p1;
        else if (le23)
            min = p2;
        else
            min = p3;

        if (!lt12 && le31)
            max = p1;
        else if (!lt23)
            max = p2;
        else
            max = p3;

        f1 = p1[W-2:0] - min[W-2:0];
        f2 = p2[W-2:0] - min[W-2:0];
        f3 = p3[W-2:0] - min[W-2:0];
        o1 = {tag, f1};
        o2 = {tag, f2};
        o3 = {tag, f3};
    end

endmodule

// File: rtl/tri_bbox_seq.sv
// Triangle bounding-box setup sequencer. Accepts one triangle per handshake,
// runs an x pass then a y pass through a single shared subtractor triple and
// min3_sel selector, and presents the box plus tagged per-vertex offsets.
// Optional build macro: TRI_BBOX_DEGEN_EN adds the zero-extent 'degen' flag;
// without it 'degen' is tied low and the compare logic is not built.
module tri_bbox_seq
    import tri_bbox_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] x3,
    input  logic [W-1:0] y1,
    input  logic [W-1:0] y2,
    input  logic [W-1:0] y3,
    input  logic         cancel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] min_x,
    output logic [W-1:0] max_x,
    output logic [W-1:0] min_y,
    output logic [W-1:0] max_y,
    output logic [W-1:0] ox1,
    output logic [W-1:0] ox2,
    output logic [W-1:0] ox3,
    output logic [W-1:0] oy1,
    output logic [W-1:0] oy2,
    output logic [W-1:0] oy3,
    output logic         degen
);

    state_t state, next_state;

    logic [W-1:0] x1_r, x2_r, x3_r, y1_r, y2_r, y3_r;
    logic [W-1:0] d12_r, d23_r, d31_r;
    logic [W-1:0] p1, p2, p3;
    logic         pass_y;
    logic [W-1:0] sel_min, sel_max, sel_o1, sel_o2, sel_o3;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state sequencing; cancel aborts any in-flight triangle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (in_valid) next_state = ST_SUB_X;
            ST_SUB_X: next_state = ST_CMP_X;
            ST_CMP_X: next_state = ST_SUB_Y;
            ST_SUB_Y: next_state = ST_CMP_Y;
            ST_CMP_Y: next_state = ST_DONE;
            ST_DONE:  if (out_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
        if (cancel && (state != ST_IDLE))
            next_state = ST_IDLE;
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // Route the active axis onto the shared subtractors and selector.
    always_comb begin
        pass_y = (state == ST_SUB_Y) || (state == ST_CMP_Y);
        p1 = pass_y ? y1_r : x1_r;
        p2 = pass_y ? y2_r : x2_r;
        p3 = pass_y ? y3_r : x3_r;
    end

    // Capture the six coordinates on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1_r <= '0; x2_r <= '0; x3_r <= '0;
            y1_r <= '0; y2_r <= '0; y3_r <= '0;
        end else if ((state == ST_IDLE) && in_valid) begin
            x1_r <= x1; x2_r <= x2; x3_r <= x3;
            y1_r <= y1; y2_r <= y2; y3_r <= y3;
        end
    end

    // Shared subtractor triple, registered during either SUB state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d12_r <= '0;
            d23_r <= '0;
            d31_r <= '0;
        end else if ((state == ST_SUB_X) || (state == ST_SUB_Y)) begin
            d12_r <= p1 - p2;
            d23_r <= p2 - p3;
            d31_r <= p3 - p1;
        end
    end

    min3_sel u_sel (
        .p1  (p1),
        .p2  (p2),
        .p3  (p3),
        .d12 (d12_r),
        .d23 (d23_r),
        .d31 (d31_r),
        .tag (pass_y ? TAG_Y : TAG_X),
        .min (sel_min),
        .max (sel_max),
        .o1  (sel_o1),
        .o2  (sel_o2),
        .o3  (sel_o3)
    );

    // Result registers; a cancelled pass leaves the previous results intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_x <= '0; max_x <= '0; ox1 <= '0; ox2 <= '0; ox3 <= '0;
            min_y <= '0; max_y <= '0; oy1 <= '0; oy2 <= '0; oy3 <= '0;
        end else if (!cancel) begin
            if (state == ST_CMP_X) begin
                min_x <= sel_min;
                max_x <= sel_max;
                ox1   <= sel_o1;
                ox2   <= sel_o2;
                ox3   <= sel_o3;
            end
            if (state == ST_CMP_Y) begin
                min_y <= sel_min;
                max_y <= sel_max;
                oy1   <= sel_o1;
                oy2   <= sel_o2;
                oy3   <= sel_o3;
            end
        end
    end

`ifdef TRI_BBOX_DEGEN_EN
    // Flag a zero-width or zero-height box alongside the y results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            degen <= 1'b0;
        else if ((state == ST_CMP_Y) && !cancel)
            degen <= (min_x == max_x) || (sel_min == sel_max);
    end
`else
    assign degen = 1'b0;
`endif

endmodule

// File: tb/tb_tri_bbox_seq.sv
// Self-checking bench for tri_bbox_seq using directed triangles with
// hand-computed boxes and offsets.
module tb_tri_bbox_seq;
    import tri_bbox_seq_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [W-1:0] x1, x2, x3, y1, y2, y3;
    logic         cancel, out_valid, out_ready;
    logic [W-1:0] min_x, max_x, min_y, max_y;
    logic [W-1:0] ox1, ox2, ox3, oy1, oy2, oy3;
    logic         degen;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;
    int seen;

`ifdef TRI_BBOX_DEGEN_EN
    localparam logic DEGEN_ON = 1'b1;
`else
    localparam logic DEGEN_ON = 1'b0;
`endif

    tri_bbox_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .x3(x3), .y1(y1), .y2(y2), .y3(y3),
        .cancel(cancel),
        .out_valid(out_valid), .out_ready(out_ready),
        .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y),
        .ox1(ox1), .ox2(ox2), .ox3(ox3),
        .oy1(oy1), .oy2(oy2), .oy3(oy3),
        .degen(degen)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Wait for in_ready, present one triangle and let it be accepted.
    task automatic applyStimulus(input int a1, input int a2, input int a3,
                                 input int b1, input int b2, input int b3);
        int budget = 0;
        @(negedge clk);
        while (!in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        x1 = a1; x2 = a2; x3 = a3;
        y1 = b1; y2 = b2; y3 = b3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after accept until out_valid appears (bounded).
    task automatic waitResult(output int l);
        l = 0;
        while (!out_valid && l < 20) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic checkBox(input string t,
                            input logic [W-1:0] e_minx, input logic [W-1:0] e_maxx,
                            input logic [W-1:0] e_ox1, input logic [W-1:0] e_ox2, input logic [W-1:0] e_ox3,
                            input logic [W-1:0] e_miny, input logic [W-1:0] e_maxy,
                            input logic [W-1:0] e_oy1, input logic [W-1:0] e_oy2, input logic [W-1:0] e_oy3,
                            input logic e_degen);
        checkOutput($sformatf("%s.out_valid", t), 32'(out_valid), 32'd1);
        checkOutput($sformatf("%s.in_ready", t), 32'(in_ready), 32'd0);
        checkOutput($sformatf("%s.min_x", t), min_x, e_minx);
        checkOutput($sformatf("%s.max_x", t), max_x, e_maxx);
        checkOutput($sformatf("%s.ox1", t), ox1, e_ox1);
        checkOutput($sformatf("%s.ox2", t), ox2, e_ox2);
        checkOutput($sformatf("%s.ox3", t), ox3, e_ox3);
        checkOutput($sformatf("%s.min_y", t), min_y, e_miny);
        checkOutput($sformatf("%s.max_y", t), max_y, e_maxy);
        checkOutput($sformatf("%s.oy1", t), oy1, e_oy1);
        checkOutput($sformatf("%s.oy2", t), oy2, e_oy2);
        checkOutput($sformatf("%s.oy3", t), oy3, e_oy3);
        checkOutput($sformatf("%s.degen", t), 32'(degen), 32'(e_degen));
    endtask

    // Consume the result and confirm the return to IDLE on the next edge.
    task automatic releaseResult(input string t);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput($sformatf("%s.rel_out_valid", t), 32'(out_valid), 32'd0);
        checkOutput($sformatf("%s.rel_in_ready", t), 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; cancel = 1'b0; out_ready = 1'b0;
        x1 = '0; x2 = '0; x3 = '0; y1 = '0; y2 = '0; y3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst.min_x", min_x, 32'd0);
        checkOutput("rst.oy3", oy3, 32'd0);
        checkOutput("rst.degen", 32'(degen), 32'd0);
        rst = 1'b0;

        // Basic triangle, then 10 cycles of backpressure in DONE.
        applyStimulus(10, 4, 7, 2, 9, 9);
        waitResult(lat);
        checkOutput("basic.latency", 32'(lat), 32'd4);
        checkBox("basic", 32'd4, 32'd10, 32'd6, 32'd0, 32'd3,
                 32'd2, 32'd9, 32'h8000_0000, 32'h8000_0007, 32'h8000_0007, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp.out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp.in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp.max_x", max_x, 32'd10);
            checkOutput("bp.oy2", oy2, 32'h8000_0007);
        end
        releaseResult("basic");

        // Negative coordinates with an x tie at the minimum.
        applyStimulus(-5, -5, 3, 0, -8, 4);
        waitResult(lat);
        checkOutput("neg.latency", 32'(lat), 32'd4);
        checkBox("neg", 32'hFFFF_FFFB, 32'd3, 32'd0, 32'd0, 32'd8,
                 32'hFFFF_FFF8, 32'd4, 32'h8000_0008, 32'h8000_0000, 32'h8000_000C, 1'b0);
        releaseResult("neg");

        // Cancel during CMP_X: abort, no result, then a clean triangle.
        applyStimulus(100, -20, 50, -3, -3, -3);
        @(posedge clk);
        #1;
        checkOutput("cancel.busy", 32'(in_ready), 32'd0);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        checkOutput("cancel.in_ready", 32'(in_ready), 32'd1);
        checkOutput("cancel.out_valid", 32'(out_valid), 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checkOutput("cancel.no_result", 32'(seen), 32'd0);

        applyStimulus(100, -20, 50, -3, -3, -3);
        waitResult(lat);
        checkOutput("after_cancel.latency", 32'(lat), 32'd4);
        checkBox("after_cancel", 32'hFFFF_FFEC, 32'd100, 32'd120, 32'd0, 32'd70,
                 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                 DEGEN_ON);
        releaseResult("after_cancel");

        // Zero-width box.
        applyStimulus(3, 3, 3, 1, 5, 9);
        waitResult(lat);
        checkOutput("degen.latency", 32'(lat), 32'd4);
        checkBox("degen", 32'd3, 32'd3, 32'd0, 32'd0, 32'd0,
                 32'd1, 32'd9, 32'h8000_0000, 32'h8000_0004, 32'h8000_0008, DEGEN_ON);
        releaseResult("degen");

        // Asynchronous reset while in SUB_Y.
        applyStimulus(10, 4, 7, 2, 9, 9);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst.in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst.min_x", min_x, 32'd0);
        checkOutput("midrst.max_y", max_y, 32'd0);
        checkOutput("midrst.oy3", oy3, 32'd0);
        checkOutput("midrst.degen", 32'(degen), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Recovery after reset.
        applyStimulus(-5, -5, 3, 0, -8, 4);
        waitResult(lat);
        checkOutput("recover.latency", 32'(lat), 32'd4);
        checkBox("recover", 32'hFFFF_FFFB, 32'd3, 32'd0, 32'd0, 32'd8,
                 32'hFFFF_FFF8, 32'd4, 32'h8000_0008, 32'h8000_0000, 32'h8000_000C, 1'b0);
        releaseResult("recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
